// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry in-order buffer between the ALU and writeback, retiring flags on pop.
// Optional macro FLAG_BYPASS_EN makes a retiring entry's z/n visible on flag_z/flag_n in the pop cycle.
module alu_result_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_z,
  input  logic              in_n,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_setf,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic              flag_z,
  output logic              flag_n
);

  logic [DATA_W-1:0] mem_result [2];
  logic [RD_W-1:0]   mem_rd     [2];
  logic              mem_z      [2];
  logic              mem_n      [2];
  logic              mem_wen    [2];
  logic              mem_setf   [2];

  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       flag_z_q;
  logic       flag_n_q;
  logic       push;
  logic       pop;
  logic       retire;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // A flush in the same cycle cancels the retirement, so flags stay put.
  assign retire    = pop && mem_setf[rd_ptr] && !flush;

  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_rd     = out_valid ? mem_rd[rd_ptr]     : '0;
  assign out_wen    = out_valid ? mem_wen[rd_ptr]    : 1'b0;

  // Payload storage needs no reset: out_valid masks anything stale.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_rd[wr_ptr]     <= in_rd;
      mem_z[wr_ptr]      <= in_z;
      mem_n[wr_ptr]      <= in_n;
      mem_wen[wr_ptr]    <= in_wen;
      mem_setf[wr_ptr]   <= in_setf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (retire) begin
        flag_z_q <= mem_z[rd_ptr];
        flag_n_q <= mem_n[rd_ptr];
      end
    end
  end

`ifdef FLAG_BYPASS_EN
  assign flag_z = retire ? mem_z[rd_ptr] : flag_z_q;
  assign flag_n = retire ? mem_n[rd_ptr] : flag_n_q;
`else
  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DATA_W, default 32, result datapath width.
REQ-002 Parameter RD_W, default 5, destination register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  ALU result presented this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  DATA_W  ALU Out value.
REQ-008 in_z  input  1  ALU zero flag.
REQ-009 in_n  input  1  ALU negative flag.
REQ-010 in_rd  input  RD_W  destination register index.
REQ-011 in_wen  input  1  entry writes the register file.
REQ-012 in_setf  input  1  entry updates architectural flags.
REQ-013 flush  input  1  discard all buffered entries.
REQ-014 out_valid  output  1  head entry available to writeback.
REQ-015 out_ready  input  1  writeback consumes head entry.
REQ-016 out_result  output  DATA_W  head entry result.
REQ-017 out_rd  output  RD_W  head entry destination.
REQ-018 out_wen  output  1  head entry write enable.
REQ-019 flag_z  output  1  architectural zero flag.
REQ-020 flag_n  output  1  architectural negative flag.

Function
REQ-021 Stage SHALL be a 2-entry in-order FIFO of {result, z, n, rd, wen, setf} with 1-bit read/write pointers and a 2-bit count (0..2).
REQ-022 in_ready SHALL equal (count != 2), driven from registered state only, never from out_ready.
REQ-023 Push SHALL occur on in_valid && in_ready; pop SHALL occur on out_valid && out_ready.
REQ-024 out_valid SHALL equal (count != 0); out_result/out_rd/out_wen SHALL come from the head entry; minimum latency push-to-out_valid is 1 cycle, no same-cycle pass-through.
REQ-025 Simultaneous push and pop at count 1 SHALL leave count 1; at count 0 only push is possible; at count 2 only pop is possible.
REQ-026 Pointers SHALL wrap 1->0 without loss; ordering SHALL be strictly FIFO.
REQ-027 On a pop whose entry has setf=1, flag_z/flag_n registers SHALL load that entry's z/n; pops with setf=0 SHALL leave flags unchanged.
REQ-028 Flags SHALL reflect only retired (popped) entries, never buffered ones.
REQ-029 flush SHALL, on the next edge, set count to 0 and both pointers to 0, overriding any same-cycle push and pop; a same-cycle pop with setf=1 SHALL NOT update flags.
REQ-030 flush SHALL NOT alter flag_z/flag_n.
REQ-031 When out_valid=0, out_result, out_rd and out_wen SHALL be driven 0.

Reset
REQ-032 rst_n low SHALL immediately clear count, pointers, flag_z=0, flag_n=0, giving out_valid=0, in_ready=1, out_wen=0, out_result=0, out_rd=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries; no pop or flag update SHALL occur in the cycle rst_n deasserts unless handshake conditions hold after release.

Configuration
REQ-034 Macro FLAG_BYPASS_EN SHALL control flag output timing.
REQ-035 With FLAG_BYPASS_EN defined, flag_z/flag_n SHALL combinationally show the popping entry's z/n in the pop cycle when setf=1 and flush=0, else the flag registers.
REQ-036 Without FLAG_BYPASS_EN, flag_z/flag_n SHALL be the flag registers directly, updating the cycle after the pop.

Verification
REQ-037 Reset, then push result=0x00000005, rd=3, wen=1, setf=1, z=0, n=0 with out_ready=1 -> out_valid next cycle with out_result=0x5, out_rd=3; flags 0/0.
REQ-038 out_ready=0, push 0x11, 0x22, 0x33 back-to-back -> third push stalls (in_ready=0 after second); release out_ready -> outputs 0x11, 0x22, then 0x33 in order.
REQ-039 Push 0x00000000 (z=1, setf=1) then 0x80000000 (n=1, setf=0), both popped -> flag_z=1, flag_n=0 after both retire.
REQ-040 Two entries buffered, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, count 0, in_ready=1, flags unchanged.
REQ-041 Pop of setf=1, n=1 entry -> flag_n=1 in pop cycle with FLAG_BYPASS_EN, one cycle later without.
REQ-042 Drop rst_n asynchronously while count=2 -> out_valid=0, flags 0 immediately, before next clk edge.
